// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states and
// default widths matching the 16x32 register file. Optional build macro: MULDIV_SIGNED_EN.
package muldiv_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_MULLO = 2'b00,
    OP_MULHI = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
`ifdef MULDIV_SIGNED_EN
    S_FIXUP = 2'd3,
`endif
    S_DONE  = 2'd2
  } state_e;

  // Bit 1 of the op code separates divide-family from multiply-family operations.
  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/write-back bundle between the controller, the register file and muldiv_unit.
// Carries signedOp only when MULDIV_SIGNED_EN is defined.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
);

  logic                  start;
  op_e                   op;
  logic [WIDTH-1:0]      operandA;
  logic [WIDTH-1:0]      operandB;
  logic [REG_ADDR_W-1:0] destRegister;
`ifdef MULDIV_SIGNED_EN
  logic                  signedOp;
`endif
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      writeData;
  logic [REG_ADDR_W-1:0] writeRegister;
  logic                  writeEnable;

  modport master (
    output start, op, operandA, operandB, destRegister,
`ifdef MULDIV_SIGNED_EN
    output signedOp,
`endif
    input  busy, done, writeData, writeRegister, writeEnable
  );

  modport slave (
    input  start, op, operandA, operandB, destRegister,
`ifdef MULDIV_SIGNED_EN
    input  signedOp,
`endif
    output busy, done, writeData, writeRegister, writeEnable
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Shared accumulator datapath: upper half is product-high / remainder, lower half is
// multiplier-shift / quotient. Sign fixup logic present only with MULDIV_SIGNED_EN.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
`ifdef MULDIV_SIGNED_EN
  input  logic             fixup_i,
  input  logic             signed_i,
`endif
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  op_e                op_q, op_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;

`ifdef MULDIV_SIGNED_EN
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;

  assign sign_a = signed_i & a_i[WIDTH-1];
  assign sign_b = signed_i & b_i[WIDTH-1];
`else
  assign sign_a = 1'b0;
  assign sign_b = 1'b0;
`endif

  assign a_mag = sign_a ? -a_i : a_i;
  assign b_mag = sign_b ? -b_i : b_i;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // The partial remainder stays below the divisor, so the shifted value needs one extra
  // bit and a successful subtraction always fits back into WIDTH bits.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    op_d   = op_q;
`ifdef MULDIV_SIGNED_EN
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
`endif
    if (load_i) begin
      op_d = op_i;
      if (!is_div(op_i)) begin
        acc_d  = {{WIDTH{1'b0}}, b_mag};
        opnd_d = a_mag;
`ifdef MULDIV_SIGNED_EN
        neg_lo_d = sign_a ^ sign_b;
        neg_hi_d = sign_a ^ sign_b;
`endif
      end else if (b_i == '0) begin
        // Divide by zero: quotient all ones, remainder the raw dividend, no fixup.
        acc_d  = {a_i, {WIDTH{1'b1}}};
        opnd_d = '0;
`ifdef MULDIV_SIGNED_EN
        neg_lo_d = 1'b0;
        neg_hi_d = 1'b0;
`endif
      end else begin
        acc_d  = {{WIDTH{1'b0}}, a_mag};
        opnd_d = b_mag;
`ifdef MULDIV_SIGNED_EN
        neg_lo_d = sign_a ^ sign_b;
        neg_hi_d = sign_a;
`endif
      end
    end else if (step_i) begin
      if (!is_div(op_q)) begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end else if (div_ge) begin
        acc_d = {div_sub, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end
`ifdef MULDIV_SIGNED_EN
    else if (fixup_i) begin
      if (!is_div(op_q)) begin
        acc_d = neg_lo_q ? -acc_q : acc_q;
      end else begin
        acc_d[2*WIDTH-1:WIDTH] = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        acc_d[WIDTH-1:0]       = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      op_q   <= OP_MULLO;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      op_q   <= op_d;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  // Odd op codes (MULHI, REMU) read the upper half of the accumulator.
  assign result_o = op_q[0] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: IDLE -> RUN (WIDTH steps) -> DONE, with an extra
// FIXUP cycle for sign correction when MULDIV_SIGNED_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  load, step, div_zero;
  logic [WIDTH-1:0]      result;
`ifdef MULDIV_SIGNED_EN
  logic                  fixup;
`endif

  assign div_zero = is_div(bus.op) && (bus.operandB == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    load    = 1'b0;
    step    = 1'b0;
`ifdef MULDIV_SIGNED_EN
    fixup   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          dest_d  = bus.destRegister;
          cnt_d   = '0;
          state_d = div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef MULDIV_SIGNED_EN
          state_d = S_FIXUP;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_FIXUP: begin
        fixup   = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
    end
  end

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
`ifdef MULDIV_SIGNED_EN
    .fixup_i  (fixup),
    .signed_i (bus.signedOp),
`endif
    .op_i     (bus.op),
    .a_i      (bus.operandA),
    .b_i      (bus.operandB),
    .result_o (result)
  );

  // Write-back fields are held at zero outside the DONE cycle.
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.writeEnable   = bus.done;
  assign bus.writeData     = bus.done ? result : '0;
  assign bus.writeRegister = bus.done ? dest_q : '0;

endmodule
